// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs decoded RV32I fields into instruction words and streams them to instruction memory
// Optional U/J immediate formats are enabled by defining INSTR_ENC_UJ_EN.
module instr_encoder #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        imm_src,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              clr_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              err_range,
    output logic              err_align,
    output logic              err_type,
    output logic [CNT_W-1:0]  instr_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [6:0]        OP_IMM    = 7'b0010011;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       enc_word;
    logic              bad_range;
    logic              bad_align;
    logic              bad_type;
    logic              is_shift;
    logic              fits12;
    logic              fits13;
    logic              handshake;
    logic              legal;

    // Sign-extension tests: all bits above the field's sign bit must match it.
    assign fits12 = (&imm[31:11]) || !(|imm[31:11]);
    assign fits13 = (&imm[31:12]) || !(|imm[31:12]);
    assign is_shift = (opcode == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));

    assign in_ready  = !rst && (!out_valid || out_ready);
    assign handshake = in_valid && in_ready;
    assign legal     = !(bad_range || bad_align || bad_type);
    assign base_addr = addr_load ? addr_in : addr_cnt;

`ifdef INSTR_ENC_UJ_EN
    logic fits21;
    assign fits21 = (&imm[31:20]) || !(|imm[31:20]);
`endif

    always_comb begin
        enc_word  = '0;
        bad_range = 1'b0;
        bad_align = 1'b0;
        bad_type  = 1'b0;
        case (imm_src)
            3'b000: begin
                if (is_shift) begin
                    enc_word  = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                    bad_range = |imm[31:5];
                end else begin
                    enc_word  = {imm[11:0], rs1, funct3, rd, opcode};
                    bad_range = !fits12;
                end
            end
            3'b001: begin
                enc_word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                bad_range = !fits12;
            end
            3'b101: begin
                enc_word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                // 4095 sign-extends cleanly but exceeds the largest even offset.
                bad_range = !fits13 || (imm[12:0] == 13'h0FFF);
                bad_align = imm[0];
            end
`ifdef INSTR_ENC_UJ_EN
            3'b010: begin
                enc_word  = {imm[31:12], rd, opcode};
                bad_align = |imm[11:0];
            end
            3'b011: begin
                enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                bad_range = !fits21 || (imm[20:0] == 21'h0FFFFF);
                bad_align = imm[0];
            end
`endif
            default: bad_type = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            addr_cnt  <= '0;
            err_range <= 1'b0;
            err_align <= 1'b0;
            err_type  <= 1'b0;
            instr_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            // A fresh error wins over a simultaneous clear.
            err_range <= (err_range && !clr_err) || (handshake && bad_range);
            err_align <= (err_align && !clr_err) || (handshake && bad_align);
            err_type  <= (err_type  && !clr_err) || (handshake && bad_type);

            if (handshake && legal) begin
                out_valid <= 1'b1;
                wr_addr   <= base_addr;
                wr_data   <= enc_word;
                addr_cnt  <= base_addr + ADDR_STEP;
                if (instr_cnt != '1) begin
                    instr_cnt <= instr_cnt + CNT_ONE;
                end
            end else begin
                if (handshake || out_ready) begin
                    out_valid <= 1'b0;
                end
                if (addr_load) begin
                    addr_cnt <= addr_in;
                end
                if (handshake && err_cnt != '1) begin
                    err_cnt <= err_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder against a behavioural model
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_src;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        addr_load;
    logic [31:0] addr_in;
    logic        clr_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        err_range;
    logic        err_align;
    logic        err_type;
    logic [15:0] instr_cnt;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;

    instr_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .imm_src(imm_src), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .addr_load(addr_load), .addr_in(addr_in), .clr_err(clr_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .err_range(err_range), .err_align(err_align), .err_type(err_type),
        .instr_cnt(instr_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit        m_valid;
    bit [31:0] m_addr, m_data, m_cnt;
    bit        m_er, m_ea, m_et;
    int        m_ic, m_ec;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        m_valid = 0; m_addr = 0; m_data = 0; m_cnt = 0;
        m_er = 0; m_ea = 0; m_et = 0; m_ic = 0; m_ec = 0;
    endfunction

    // Encoding and legality computed from field definitions with integer arithmetic.
    function automatic void ref_enc(input int src, input int opc, input int f3, input int f7,
                                    input int d, input int s1, input int s2, input int iv,
                                    output bit [31:0] w, output bit er, output bit ea, output bit et);
        w = 0; er = 0; ea = 0; et = 0;
        case (src)
            0: begin
                if (opc == 19 && (f3 == 1 || f3 == 5)) begin
                    er = (iv < 0) || (iv > 31);
                    w = (f7 << 25) | ((iv & 31) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | opc;
                end else begin
                    er = (iv < -2048) || (iv > 2047);
                    w = ((iv & 4095) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | opc;
                end
            end
            1: begin
                er = (iv < -2048) || (iv > 2047);
                w = (((iv >>> 5) & 127) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | ((iv & 31) << 7) | opc;
            end
            5: begin
                er = (iv < -4096) || (iv > 4094);
                ea = (iv & 1) != 0;
                w = (((iv >>> 12) & 1) << 31) | (((iv >>> 5) & 63) << 25) | (s2 << 20) | (s1 << 15)
                  | (f3 << 12) | (((iv >>> 1) & 15) << 8) | (((iv >>> 11) & 1) << 7) | opc;
            end
`ifdef INSTR_ENC_UJ_EN
            2: begin
                ea = (iv & 4095) != 0;
                w = (iv & 32'hFFFFF000) | (d << 7) | opc;
            end
            3: begin
                er = (iv < -(1 << 20)) || (iv > (1 << 20) - 2);
                ea = (iv & 1) != 0;
                w = (((iv >>> 20) & 1) << 31) | (((iv >>> 1) & 1023) << 21) | (((iv >>> 11) & 1) << 20)
                  | (((iv >>> 12) & 255) << 12) | (d << 7) | opc;
            end
`endif
            default: et = 1;
        endcase
    endfunction

    // Inputs are assumed driven just after a falling edge; advances one clock and compares.
    task automatic cycle();
        bit [31:0] w;
        bit er, ea, et, hs, ok;
        bit [31:0] base;
        #1;
        check("in_ready", in_ready, !m_valid || out_ready);
        ref_enc(imm_src, opcode, funct3, funct7, rd, rs1, rs2, int'(imm), w, er, ea, et);
        hs = in_valid && (!m_valid || out_ready);
        ok = !(er || ea || et);
        m_er = (m_er && !clr_err) || (hs && er);
        m_ea = (m_ea && !clr_err) || (hs && ea);
        m_et = (m_et && !clr_err) || (hs && et);
        base = addr_load ? addr_in : m_cnt;
        if (hs && ok) begin
            m_valid = 1; m_addr = base; m_data = w; m_cnt = base + 4;
            if (m_ic < 65535) m_ic++;
        end else begin
            if (hs || out_ready) m_valid = 0;
            if (addr_load) m_cnt = addr_in;
            if (hs && m_ec < 65535) m_ec++;
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_valid);
        check("wr_addr", wr_addr, m_addr);
        check("wr_data", wr_data, m_data);
        check("err_range", err_range, m_er);
        check("err_align", err_align, m_ea);
        check("err_type", err_type, m_et);
        check("instr_cnt", instr_cnt, 64'(m_ic));
        check("err_cnt", err_cnt, 64'(m_ec));
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; addr_load = 0; clr_err = 0; out_ready = 1;
    endtask

    task automatic bundle(input int src, input int opc, input int f3, input int d,
                          input int s1, input int s2, input int iv);
        in_valid = 1; imm_src = 3'(src); opcode = 7'(opc); funct3 = 3'(f3);
        rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = iv;
    endtask

    int bnd [22] = '{-4097, -4096, -4095, -2049, -2048, -3, -1, 0, 1, 31, 32, 2047,
                     2048, 4094, 4095, 4096, 12288, (1 << 20) - 2, (1 << 20) - 1,
                     -(1 << 20), -(1 << 20) - 1, 4097};

    initial begin
        rst = 1; idle(); imm_src = 0; opcode = 0; funct3 = 0; funct7 = 0;
        rd = 0; rs1 = 0; rs2 = 0; imm = 0; addr_in = 0;
        m_reset();
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_cnts", {instr_cnt, err_cnt}, 0);
        check("rst_flags", {err_range, err_align, err_type}, 0);
        rst = 0;

        addr_load = 1; addr_in = 32'h100; cycle();
        idle(); bundle(0, 8'h13, 0, 1, 0, 0, 5); cycle();
        check("i_word", wr_data, 32'h00500093);
        check("i_addr", wr_addr, 32'h100);
        check("i_cnt", instr_cnt, 1);
        bundle(1, 8'h23, 2, 0, 1, 2, 8); cycle();
        check("s_word", wr_data, 32'h0020A423);
        check("s_addr", wr_addr, 32'h104);
        bundle(5, 8'h63, 0, 0, 1, 2, -4); cycle();
        check("b_word", wr_data, 32'hFE208EE3);
        bundle(5, 8'h63, 0, 0, 1, 2, -3); cycle();
        check("b_odd_align", err_align, 1);
        check("b_odd_errcnt", err_cnt, 1);
        check("b_odd_valid", out_valid, 0);
        bundle(0, 8'h13, 0, 1, 0, 0, 2048); cycle();
        check("i_2048_range", err_range, 1);
        check("i_2048_errcnt", err_cnt, 2);
        bundle(0, 8'h13, 0, 1, 0, 0, -2049); cycle();
        check("i_m2049_valid", out_valid, 0);
        idle(); clr_err = 1; cycle();
        check("clr_flags", {err_range, err_align, err_type}, 0);
        check("clr_keep_cnt", instr_cnt, 3);
        idle(); bundle(0, 8'h13, 0, 2, 0, 0, 7); cycle();
        check("after_err_addr", wr_addr, 32'h10C);

        // Stall with a pending bundle, then release for two back-to-back words.
        out_ready = 0; bundle(0, 8'h13, 0, 3, 0, 0, 9);
        repeat (3) cycle();
        check("stall_in_ready", in_ready, 0);
        out_ready = 1; cycle();
        bundle(0, 8'h13, 0, 4, 0, 0, 10); cycle();
        check("b2b_addr", wr_addr, 32'h114);

        idle(); addr_load = 1; addr_in = 32'hFFFFFFFC; bundle(0, 8'h13, 0, 1, 0, 0, 1); cycle();
        check("wrap_addr0", wr_addr, 32'hFFFFFFFC);
        addr_load = 0; cycle();
        check("wrap_addr1", wr_addr, 32'h0);

        for (int n = 0; n < 600; n++) begin
            int r;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            addr_load = ($urandom_range(0, 15) == 0);
            addr_in   = $urandom & 32'hFFFFFFFC;
            clr_err   = ($urandom_range(0, 15) == 0);
            imm_src   = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 7))
                      : ((r = $urandom_range(0, 2)) == 0 ? 3'd0 : (r == 1 ? 3'd1 : 3'd5));
            opcode    = ($urandom_range(0, 1) != 0) ? 7'h13 : 7'($urandom);
            funct3    = 3'($urandom);
            funct7    = 7'($urandom);
            rd        = 5'($urandom);
            rs1       = 5'($urandom);
            rs2       = 5'($urandom);
            case ($urandom_range(0, 3))
                0: imm = bnd[$urandom_range(0, 21)];
                1: imm = int'($urandom_range(0, 8191)) - 4096;
                2: imm = $urandom;
                default: imm = $urandom_range(0, 40);
            endcase
            cycle();
        end

        // Reset while a word is held must drop out_valid without a clock edge.
        idle(); out_ready = 0; bundle(0, 8'h13, 0, 1, 0, 0, 3); cycle();
        check("pre_rst_valid", out_valid, 1);
        rst = 1;
        #1;
        check("async_valid", out_valid, 0);
        check("async_cnts", {instr_cnt, err_cnt}, 0);
        check("async_addr", wr_addr, 0);
        check("async_in_ready", in_ready, 0);
        m_reset();
        @(negedge clk); rst = 0; idle();
        bundle(0, 8'h13, 0, 1, 0, 0, 3); cycle();
        check("post_rst_addr", wr_addr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
